// File: rtl/gauss_pkg.sv
// Shared constants for the Gaussian polynomial collector: modulus, output width,
// default sampler geometry, FSM encoding and the signed-to-[0,Q) reduction helper.
package gauss_pkg;

    localparam int unsigned Q               = 3329;
    localparam int unsigned QW              = 12;
    localparam int unsigned DEF_PARALLELISM = 4;
    localparam int unsigned DEF_VALUE_WIDTH = 13;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StFlush = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // v is a sign-extended coefficient with |v| < q; negatives fold to q + v.
    function automatic logic [QW-1:0] mod_q(input logic [31:0] v, input int unsigned q);
        return QW'(v[31] ? v + q : v);
    endfunction

endpackage

// File: rtl/gauss_group_fifo.sv
// Synchronous register-based FIFO holding whole sampler groups, with occupancy count.
module gauss_group_fifo #(
    parameter int unsigned WIDTH = 52,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] rd_data_o,
    output logic [CW-1:0]    count_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    always_comb begin
        full     = (count_q == CW'(DEPTH));
        do_rd    = rd_en_i & (count_q != '0);
        // A pop frees a slot in the same cycle, so a full FIFO can still accept.
        do_wr    = wr_en_i & (~full | do_rd);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) begin
            mem_d[wr_ptr_q] = wr_data_i;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd_data_o = mem_q[rd_ptr_q];
    assign count_o   = count_q;
    assign empty_o   = (count_q == '0);

endmodule

// File: rtl/gauss_poly_collector.sv
// Collects sampler groups into one polynomial: credit-limited random-word requests,
// group buffering, lane serialisation and reduction of each coefficient into [0,Q).
module gauss_poly_collector
    import gauss_pkg::QW;
    import gauss_pkg::DEF_PARALLELISM;
    import gauss_pkg::DEF_VALUE_WIDTH;
    import gauss_pkg::StIdle;
    import gauss_pkg::StRun;
    import gauss_pkg::StFlush;
    import gauss_pkg::StDone;
    import gauss_pkg::mod_q;
#(
    parameter int unsigned PARALLELISM     = DEF_PARALLELISM,
    parameter int unsigned VALUE_WIDTH     = DEF_VALUE_WIDTH,
    parameter int unsigned N_COEFFS        = 256,
    parameter int unsigned FIFO_DEPTH      = 8,
    parameter int unsigned SAMPLER_LATENCY = 4,
    parameter int unsigned Q               = gauss_pkg::Q
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    output logic                               busy,
    output logic                               done,
    input  logic                               rng_valid,
    output logic                               rng_take,
    input  logic                               samp_valid,
    input  logic [PARALLELISM*VALUE_WIDTH-1:0] samp_coeffs,
    output logic                               coef_valid,
    input  logic                               coef_ready,
    output logic [QW-1:0]                      coef_data,
    output logic [$clog2(N_COEFFS)-1:0]        coef_index,
    output logic                               coef_last,
    output logic                               err
);

    localparam int unsigned NGroups = N_COEFFS / PARALLELISM;
    localparam int unsigned GW      = PARALLELISM * VALUE_WIDTH;
    localparam int unsigned IdxW    = $clog2(N_COEFFS);
    localparam int unsigned LaneW   = (PARALLELISM > 1) ? $clog2(PARALLELISM) : 1;
    localparam int unsigned GaW     = $clog2(NGroups + 1);
    localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned L       = SAMPLER_LATENCY;

    logic [1:0]       state_q, state_d;
    logic [L-1:0]     inflight_q, inflight_d;
    logic [L-1:0]     stale_q, stale_d;
    logic [GaW-1:0]   ga_q, ga_d;
    logic [LaneW-1:0] lane_q, lane_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             err_q, err_d;

    logic [GW-1:0]          head;
    logic [CntW-1:0]        fifo_count;
    logic                   fifo_empty;
    logic                   fifo_wr;
    logic                   fifo_rd;
    logic                   tap;
    logic                   stale_tap;
    logic                   hs;
    logic                   last_lane;
    logic                   credit_ok;
    logic                   quota_ok;
    int unsigned            inflight_cnt;
    logic [VALUE_WIDTH-1:0] lanes [PARALLELISM];
    logic [VALUE_WIDTH-1:0] lane_val;
    logic [31:0]            lane_sext;

    gauss_group_fifo #(
        .WIDTH (GW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i (samp_coeffs),
        .rd_en_i   (fifo_rd),
        .rd_data_o (head),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty)
    );

    always_comb begin
        tap          = inflight_q[L-1];
        stale_tap    = stale_q[L-1];
        inflight_cnt = $countones(inflight_q);
        // Every outstanding request must already own a FIFO slot and a polynomial slot.
        credit_ok    = (32'(fifo_count) + inflight_cnt) < FIFO_DEPTH;
        quota_ok     = (32'(ga_q) + inflight_cnt) < NGroups;
        rng_take     = ~rst & (state_q == StRun) & rng_valid & credit_ok & quota_ok;

        fifo_wr      = samp_valid & tap;
        coef_valid   = ~fifo_empty;
        hs           = coef_valid & coef_ready;
        last_lane    = (lane_q == LaneW'(PARALLELISM - 1));
        fifo_rd      = hs & last_lane;

        inflight_d    = inflight_q << 1;
        inflight_d[0] = rng_take;
        // Results of requests abandoned by a reset still return; remember where they are.
        stale_d       = rst ? ((stale_q | inflight_q) << 1) : (stale_q << 1);

        err_d = err_q | (samp_valid & ~tap & ~stale_tap);

        lane_d = lane_q;
        idx_d  = idx_q;
        if (hs) begin
            lane_d = last_lane ? '0 : lane_q + LaneW'(1);
            idx_d  = (idx_q == IdxW'(N_COEFFS - 1)) ? '0 : idx_q + IdxW'(1);
        end

        ga_d = ga_q;
        if (state_q == StIdle && start) begin
            ga_d = '0;
        end else if (fifo_wr) begin
            ga_d = ga_q + GaW'(1);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(PARALLELISM); i++) begin
            lanes[i] = head[i*VALUE_WIDTH +: VALUE_WIDTH];
        end
        lane_val   = lanes[lane_q];
        lane_sext  = {{(32 - VALUE_WIDTH){lane_val[VALUE_WIDTH-1]}}, lane_val};
        coef_data  = coef_valid ? mod_q(lane_sext, Q) : '0;
        coef_index = idx_q;
        coef_last  = coef_valid & (idx_q == IdxW'(N_COEFFS - 1));
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        err        = err_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (fifo_wr && ga_q == GaW'(NGroups - 1)) state_d = StFlush;
            StFlush: if (hs && coef_last) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            inflight_q <= '0;
            ga_q       <= '0;
            lane_q     <= '0;
            idx_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            ga_q       <= ga_d;
            lane_q     <= lane_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        stale_q <= stale_d;
    end

endmodule

// File: tb/tb_gauss_poly_collector.sv
// Directed bench for gauss_poly_collector with a fixed-latency sampler model and scoreboard.
module tb_gauss_poly_collector;

    localparam int P     = 4;
    localparam int VW    = 13;
    localparam int N     = 256;
    localparam int NG    = 64;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            busy, done, rng_take, coef_valid, coef_last, err;
    logic            rng_valid = 1'b0;
    logic            samp_valid = 1'b0;
    logic            coef_ready = 1'b0;
    logic [P*VW-1:0] samp_coeffs = '0;
    logic [11:0]     coef_data;
    logic [7:0]      coef_index;

    always #5 clk = ~clk;

    gauss_poly_collector #(
        .PARALLELISM     (P),
        .VALUE_WIDTH     (VW),
        .N_COEFFS        (N),
        .FIFO_DEPTH      (DEPTH),
        .SAMPLER_LATENCY (4),
        .Q               (3329)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .rng_valid   (rng_valid),
        .rng_take    (rng_take),
        .samp_valid  (samp_valid),
        .samp_coeffs (samp_coeffs),
        .coef_valid  (coef_valid),
        .coef_ready  (coef_ready),
        .coef_data   (coef_data),
        .coef_index  (coef_index),
        .coef_last   (coef_last),
        .err         (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    bit drv_rst = 1'b1, drv_start = 1'b0, drv_rngv = 1'b0, drv_ready = 1'b0, drv_inject = 1'b0;
    int reject_period = 0;

    // Sampler pipeline: a request taken in cycle t is returned in cycle t+4.
    bit              sh_v [1:4];
    bit              sh_rej [1:4];
    bit              sh_stale [1:4];
    logic [P*VW-1:0] sh_d [1:4];

    int req_id = 0;
    int req_cnt, acc_cnt, extra_req, hs_cnt, done_cnt, outstanding, written, popped, lane_pos;
    int credit_viol, stable_viol, cv_seen;
    logic [11:0] exp_q [$];
    logic [11:0] first_data [3];

    logic        s_busy, s_done, s_take, s_cv, s_last, s_err;
    logic [11:0] s_data, prev_data;
    logic [7:0]  s_idx, prev_idx;
    bit          prev_cv = 1'b0, prev_ready = 1'b0;

    function automatic logic [P*VW-1:0] gen_group(input int k);
        logic [P*VW-1:0] g;
        int v;
        if (k == 0) begin
            g = {13'h0000, 13'h1FF1, 13'h0005, 13'h1FFF};
        end else begin
            for (int l = 0; l < P; l++) begin
                v = ((k * 37 + l * 101) % 3001) - 1500;
                g[l*VW +: VW] = 13'(v);
            end
        end
        return g;
    endfunction

    function automatic logic [11:0] ref_mod(input logic [12:0] v);
        int s;
        s = v[12] ? int'(v) - 8192 : int'(v);
        if (s < 0) s = s + 3329;
        return 12'(s);
    endfunction

    task automatic tick();
        bit rej;
        @(negedge clk);
        rst         = drv_rst;
        start       = drv_start;
        drv_start   = 1'b0;
        rng_valid   = drv_rngv;
        coef_ready  = drv_ready;
        samp_valid  = drv_inject || (sh_v[4] && !sh_rej[4]);
        samp_coeffs = sh_v[4] ? sh_d[4] : '0;
        if (drv_rst) begin
            for (int i = 1; i <= 4; i++) sh_stale[i] = 1'b1;
        end
        #1;
        s_busy = busy; s_done = done; s_take = rng_take; s_cv = coef_valid;
        s_last = coef_last; s_err = err; s_data = coef_data; s_idx = coef_index;
        if (!drv_rst) begin
            if ((written - popped) + outstanding + (s_take ? 1 : 0) > DEPTH) credit_viol++;
            if (s_cv) cv_seen++;
            if (prev_cv && !prev_ready && (!s_cv || s_data !== prev_data || s_idx !== prev_idx))
                stable_viol++;
            if (s_take && acc_cnt >= NG) extra_req++;
            if (s_cv && drv_ready) begin
                if (exp_q.size() == 0) begin
                    check("hs_without_group", 32'(hs_cnt), 32'hFFFF_FFFF);
                end else begin
                    check("coef_data", 32'(s_data), 32'(exp_q.pop_front()));
                end
                if (hs_cnt < 3) first_data[hs_cnt] = s_data;
                check("coef_index", 32'(s_idx), 32'(hs_cnt % N));
                check("coef_last", 32'(s_last), 32'((hs_cnt % N) == N - 1));
                hs_cnt++;
                lane_pos++;
                if (lane_pos == P) begin
                    lane_pos = 0;
                    popped++;
                end
            end
            if (s_done) done_cnt++;
        end
        if (sh_v[4] && !sh_stale[4]) begin
            outstanding--;
            if (!sh_rej[4]) begin
                acc_cnt++;
                written++;
                for (int l = 0; l < P; l++) exp_q.push_back(ref_mod(sh_d[4][l*VW +: VW]));
            end
        end
        prev_cv = s_cv; prev_ready = drv_ready; prev_data = s_data; prev_idx = s_idx;
        for (int i = 4; i >= 2; i--) begin
            sh_v[i] = sh_v[i-1]; sh_rej[i] = sh_rej[i-1];
            sh_stale[i] = sh_stale[i-1]; sh_d[i] = sh_d[i-1];
        end
        sh_v[1] = s_take && !drv_rst;
        sh_rej[1] = 1'b0;
        sh_stale[1] = 1'b0;
        sh_d[1] = '0;
        if (sh_v[1]) begin
            rej = (reject_period > 0) && (req_cnt % reject_period == reject_period - 1);
            sh_rej[1] = rej;
            sh_d[1] = gen_group(req_id);
            req_id++;
            req_cnt++;
            outstanding++;
        end
    endtask

    task automatic run_poly(input int stall, input int abort_hs, input int budget);
        int c;
        req_cnt = 0; acc_cnt = 0; extra_req = 0; hs_cnt = 0; done_cnt = 0; outstanding = 0;
        written = 0; popped = 0; lane_pos = 0; credit_viol = 0; stable_viol = 0;
        exp_q.delete();
        drv_start = 1'b1;
        drv_rngv  = 1'b1;
        c = 0;
        while (done_cnt == 0 && c < budget && (abort_hs == 0 || hs_cnt < abort_hs)) begin
            drv_ready = (c >= stall);
            tick();
            if (stall > 0 && c == stall - 1) begin
                check("stall_requests", 32'(req_cnt), 32'(DEPTH));
                check("stall_rng_take", 32'(s_take), 32'd0);
                check("stall_coef_valid", 32'(s_cv), 32'd1);
            end
            c++;
        end
        check("within_budget", 32'(c < budget), 32'd1);
        drv_ready = 1'b1;
    endtask

    initial begin
        for (int i = 1; i <= 4; i++) begin
            sh_v[i] = 1'b0; sh_rej[i] = 1'b0; sh_stale[i] = 1'b0; sh_d[i] = '0;
        end
        drv_rst = 1'b1; drv_rngv = 1'b1;
        tick(); tick();
        drv_rst = 1'b0;
        tick();
        check("rst_busy", 32'(s_busy), 0);
        check("rst_done", 32'(s_done), 0);
        check("rst_rng_take", 32'(s_take), 0);
        check("rst_coef_valid", 32'(s_cv), 0);
        check("rst_err", 32'(s_err), 0);
        check("rst_coef_data", 32'(s_data), 0);
        check("rst_coef_index", 32'(s_idx), 0);
        check("rst_coef_last", 32'(s_last), 0);

        // Free-running polynomial, including the directed reduction group.
        run_poly(0, 0, 2000);
        check("a_rng_take_cycles", 32'(req_cnt), 32'd64);
        check("a_coeff_count", 32'(hs_cnt), 32'd256);
        check("a_red_minus1", 32'(first_data[0]), 32'd3328);
        check("a_red_plus5", 32'(first_data[1]), 32'd5);
        check("a_red_minus15", 32'(first_data[2]), 32'd3314);
        tick();
        check("a_busy_after_done", 32'(s_busy), 0);
        tick(); tick();
        check("a_done_once", 32'(done_cnt), 32'd1);
        check("a_err", 32'(s_err), 0);
        check("a_credit", 32'(credit_viol), 0);

        // Downstream stalled for 100 cycles.
        run_poly(100, 0, 3000);
        check("b_coeff_count", 32'(hs_cnt), 32'd256);
        check("b_requests", 32'(req_cnt), 32'd64);
        check("b_credit", 32'(credit_viol), 0);
        check("b_stable", 32'(stable_viol), 0);
        check("b_leftover", 32'(exp_q.size()), 0);
        tick();

        // Every third request rejected: 95 requests yield 64 groups.
        reject_period = 3;
        run_poly(0, 0, 3000);
        check("c_coeff_count", 32'(hs_cnt), 32'd256);
        check("c_accepted", 32'(acc_cnt), 32'd64);
        check("c_requests", 32'(req_cnt), 32'd95);
        check("c_extra_req", 32'(extra_req), 0);
        check("c_err", 32'(s_err), 0);
        reject_period = 0;
        tick();

        // Spurious sampler result while idle.
        drv_rngv = 1'b0;
        cv_seen = 0;
        drv_inject = 1'b1;
        tick();
        drv_inject = 1'b0;
        tick(); tick(); tick();
        check("d_err_set", 32'(s_err), 32'd1);
        check("d_no_coef_valid", 32'(cv_seen), 0);
        drv_rst = 1'b1;
        tick();
        drv_rst = 1'b0;
        tick();
        check("d_err_cleared", 32'(s_err), 0);

        // Reset after coefficient 100, then a fresh polynomial.
        run_poly(0, 101, 2000);
        check("e_abort_point", 32'(hs_cnt), 32'd101);
        drv_rst = 1'b1;
        tick();
        drv_rst = 1'b0;
        tick();
        check("e_rst_flags", {26'd0, s_busy, s_done, s_take, s_cv, s_last, s_err}, 0);
        check("e_rst_data", 32'(s_data), 0);
        check("e_rst_index", 32'(s_idx), 0);
        for (int i = 0; i < 6; i++) tick();
        check("e_stale_no_err", 32'(s_err), 0);
        run_poly(0, 0, 2000);
        check("e_coeff_count", 32'(hs_cnt), 32'd256);
        check("e_err", 32'(s_err), 0);
        check("e_leftover", 32'(exp_q.size()), 0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gauss_poly_collector.md
GAUSS_POLY_COLLECTOR -- requirements
Module: gauss_poly_collector

Interface
REQ-001 SHALL have parameter PARALLELISM, default 4: coefficients per sampler group.
REQ-002 SHALL have parameter VALUE_WIDTH, default 13: width of each signed sampler coefficient.
REQ-003 SHALL have parameter N_COEFFS, default 256: coefficients per polynomial; SHALL be a multiple of PARALLELISM.
REQ-004 SHALL have parameter FIFO_DEPTH, default 8: group FIFO entries; SHALL be a power of 2.
REQ-005 SHALL have parameter SAMPLER_LATENCY, default 4: fixed cycles from a sampler random_valid to its sample_valid.
REQ-006 SHALL have parameter Q, default 3329: output modulus; output width QW = 12.
REQ-007 clk  in  1  clock; all logic on rising edge.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 start  in  1  pulse; begins one polynomial when idle.
REQ-010 busy  out  1  high from the cycle after an accepted start until the done cycle.
REQ-011 done  out  1  one-cycle pulse after the last coefficient handshake.
REQ-012 rng_valid  in  1  upstream random word available.
REQ-013 rng_take  out  1  consumes the random word; drives sampler random_valid.
REQ-014 samp_valid  in  1  sampler group valid.
REQ-015 samp_coeffs  in  PARALLELISM*VALUE_WIDTH  group; lane 0 in the LSBs.
REQ-016 coef_valid  out  1  output coefficient valid.
REQ-017 coef_ready  in  1  downstream accept.
REQ-018 coef_data  out  QW  coefficient reduced into [0,Q).
REQ-019 coef_index  out  clog2(N_COEFFS)  coefficient position, 0 first.
REQ-020 coef_last  out  1  high with index N_COEFFS-1.
REQ-021 err  out  1  sticky: samp_valid seen with no request in flight.

Function
REQ-022 SHALL have FSM states IDLE, RUN, FLUSH, DONE.
REQ-023 IDLE->RUN on start; start is ignored outside IDLE.
REQ-024 Each request SHALL enter an in-flight shift register of SAMPLER_LATENCY bits, shifted every cycle.
REQ-025 In RUN, rng_take = rng_valid & (fifo_count + inflight < FIFO_DEPTH) & (groups_accepted + inflight < N_COEFFS/PARALLELISM); SHALL be 0 otherwise.
REQ-026 A group SHALL be written to the FIFO only when samp_valid and the in-flight tap is set; samp_valid=0 at the tap (sampler rejection) frees the credit without a write.
REQ-027 When samp_valid=1 and the tap is 0, the group SHALL be dropped and err set.
REQ-028 RUN->FLUSH in the cycle groups_accepted reaches N_COEFFS/PARALLELISM.
REQ-029 FSM SHALL go FLUSH->DONE on the coef_last handshake, then DONE->IDLE unconditionally; done SHALL be high in DONE.
REQ-030 Output SHALL serialize the head group lane 0 first, at one coefficient per coef_valid&coef_ready, and pop the head after its last lane.
REQ-031 coef_valid SHALL be high whenever the FIFO is non-empty; data/index SHALL be held stable while valid and not ready.
REQ-032 A group written in cycle t SHALL make coef_valid visible at cycle t+1 when the FIFO was empty.
REQ-033 Reduction: if v is negative (two's complement), coef_data = Q + v; otherwise coef_data = v. Only |v| < Q is supported.
REQ-034 A FIFO write and a FIFO pop in the same cycle SHALL both occur; fifo_count stays unchanged.
REQ-035 coef_index SHALL increment per handshake and wrap to 0 after N_COEFFS-1.

Reset
REQ-036 On rst, the following SHALL hold: FSM=IDLE; FIFO, counters and in-flight register cleared; busy=done=rng_take=coef_valid=err=0; coef_data=coef_index=coef_last=0.
REQ-037 rst mid-operation SHALL abandon the polynomial; sampler results returning afterwards SHALL be dropped without setting err.

Structure
REQ-038 Q, QW, default PARALLELISM/VALUE_WIDTH and FSM state encoding SHALL reside in shared package gauss_pkg.
REQ-039 The group FIFO SHALL be a sub-module gauss_group_fifo (sync, registered, count output).

Verification
REQ-040 The bench SHALL cover: rng_valid=1, coef_ready=1, no rejections, defaults -> rng_take high at most 64 cycles total; 256 coefficients, indices 0..255, done once, busy low next cycle.
REQ-041 The bench SHALL cover: lane value 13'h1FFF (-1) -> coef_data 3328; value 13'h0005 -> 5; 13'h1FF1 (-15) -> 3314.
REQ-042 The bench SHALL cover: coef_ready=0 for 100 cycles -> FIFO fills to 8 groups, rng_take=0, no group lost, in-flight never exceeds free space.
REQ-043 The bench SHALL cover: sampler rejecting every 3rd request -> still exactly 256 coefficients, no extra request after 64 accepted, err=0.
REQ-044 The bench SHALL cover: samp_valid injected in IDLE -> err=1, no coef_valid.
REQ-045 The bench SHALL cover: rst asserted after coefficient 100 -> all outputs 0 next cycle; a new start then yields a full 0..255 sequence.
